// File: rtl/mor1kx_store_buffer_wb32.sv
// Posted-write store buffer between the LSU and the 32-bit Wishbone bridge.
// Stores are acknowledged once queued; loads wait for the FIFO to drain, then pass straight through.
module mor1kx_store_buffer_wb32 #(
    parameter int DEPTH_WIDTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [31:0] lsu_adr_i,
    input  logic [31:0] lsu_dat_i,
    input  logic [3:0]  lsu_bsel_i,
    output logic        lsu_ack_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_dat_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    output logic [3:0]  bus_bsel_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_dat_i,
    output logic        sb_empty_o,
    output logic        sb_full_o,
    output logic        store_err_o,
    output logic [31:0] store_err_adr_o
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FULL_COUNT = {1'b1, {DEPTH_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t                 state;
    logic [31:0]            adr_mem  [DEPTH];
    logic [31:0]            dat_mem  [DEPTH];
    logic [3:0]             bsel_mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH:0]   count;
    logic                   ack_r;
    logic                   push;
    logic                   pop;
    logic                   bus_done;

    assign sb_empty_o = (count == '0);
    assign sb_full_o  = (count == FULL_COUNT);
    assign bus_done   = bus_ack_i | bus_err_i;
    // ack_r blocks a second push while the LSU is still holding the request it was just acked for
    assign push       = lsu_req_i & lsu_we_i & ~sb_full_o & ~ack_r;
    assign pop        = (state == WRITE) & bus_done;

    assign lsu_ack_o  = ack_r | ((state == READ) & bus_ack_i);
    assign lsu_err_o  = (state == READ) & bus_err_i;
    assign lsu_dat_o  = bus_dat_i;

    assign bus_req_o  = (state != IDLE);
    assign bus_we_o   = (state == WRITE);
    assign bus_adr_o  = (state == READ) ? lsu_adr_i  : adr_mem[rd_ptr];
    assign bus_bsel_o = (state == READ) ? lsu_bsel_i : bsel_mem[rd_ptr];
    assign bus_dat_o  = dat_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            adr_mem[wr_ptr]  <= lsu_adr_i;
            dat_mem[wr_ptr]  <= lsu_dat_i;
            bsel_mem[wr_ptr] <= lsu_bsel_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            ack_r           <= 1'b0;
            store_err_o     <= 1'b0;
            store_err_adr_o <= '0;
        end else begin
            ack_r       <= push;
            store_err_o <= pop & bus_err_i;
            if (pop & bus_err_i)
                store_err_adr_o <= adr_mem[rd_ptr];
            if (push)
                wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
            if (pop)
                rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_WIDTH+1)'(1);
                2'b01:   count <= count - (DEPTH_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Every access returns through IDLE, so the bridge always sees a gap between requests
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!sb_empty_o)
                        state <= WRITE;
                    else if (lsu_req_i && !lsu_we_i)
                        state <= READ;
                end
                WRITE: if (bus_done) state <= IDLE;
                READ:  if (bus_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mor1kx_store_buffer_wb32.sv
// Bench for the store buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized LSU/bus traffic.
module tb_mor1kx_store_buffer_wb32;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [31:0] lsu_adr_i = '0;
    logic [31:0] lsu_dat_i = '0;
    logic [3:0]  lsu_bsel_i = '0;
    logic        lsu_ack_o;
    logic        lsu_err_o;
    logic [31:0] lsu_dat_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_adr_o;
    logic [31:0] bus_dat_o;
    logic [3:0]  bus_bsel_o;
    logic        bus_ack_i = 1'b0;
    logic        bus_err_i = 1'b0;
    logic [31:0] bus_dat_i = '0;
    logic        sb_empty_o;
    logic        sb_full_o;
    logic        store_err_o;
    logic [31:0] store_err_adr_o;

    mor1kx_store_buffer_wb32 #(.DEPTH_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_adr_i(lsu_adr_i),
        .lsu_dat_i(lsu_dat_i), .lsu_bsel_i(lsu_bsel_i),
        .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o), .lsu_dat_o(lsu_dat_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
        .bus_dat_o(bus_dat_o), .bus_bsel_o(bus_bsel_o),
        .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_dat_i(bus_dat_i),
        .sb_empty_o(sb_empty_o), .sb_full_o(sb_full_o),
        .store_err_o(store_err_o), .store_err_adr_o(store_err_adr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  bsel;
    } entry_t;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  bsel;
    } op_t;

    int checks = 0;
    int errors = 0;

    op_t         op_q[$];
    op_t         cur_op;
    bit          lsu_active = 1'b0;
    bit          lsu_done = 1'b0;
    bit          bus_hold = 1'b0;
    bit          err_arm = 1'b0;
    logic [31:0] err_adr = '0;
    bit          fixed_rd_en = 1'b0;
    logic [31:0] fixed_rd = '0;
    int unsigned err_pct = 0;
    int unsigned gap_pct = 0;
    int unsigned wait_cnt = 0;
    int unsigned bus_delay = 0;

    // Reference model: stores in flight as a plain queue, plus what the bus is doing right now
    // (0 = quiet, 1 = draining the oldest store, 2 = forwarding the LSU load).
    entry_t      sb_q[$];
    bit          m_ack_pend = 1'b0;
    int          m_bus = 0;
    bit          m_err_pulse = 1'b0;
    logic [31:0] m_err_adr = '0;

    logic [31:0] t3_adr [4];
    bit          t3_we  [4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] bsel);
        op_t op;
        op.we = we;
        op.adr = adr;
        op.dat = dat;
        op.bsel = bsel;
        op_q.push_back(op);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_ack_pend = 1'b0;
        m_bus = 0;
        m_err_pulse = 1'b0;
        m_err_adr = '0;
    endtask

    task automatic model_step();
        bit     accepted;
        bit     finished;
        bit     was_empty;
        entry_t e;
        finished = bus_ack_i || bus_err_i;
        was_empty = (sb_q.size() == 0);
        accepted = lsu_req_i && lsu_we_i && (sb_q.size() < DEPTH) && !m_ack_pend;
        m_err_pulse = 1'b0;
        if (m_bus == 1 && finished) begin
            if (bus_err_i) begin
                m_err_pulse = 1'b1;
                m_err_adr = sb_q[0].adr;
            end
            void'(sb_q.pop_front());
        end
        if (accepted) begin
            e.adr = lsu_adr_i;
            e.dat = lsu_dat_i;
            e.bsel = lsu_bsel_i;
            sb_q.push_back(e);
        end
        m_ack_pend = accepted;
        if (m_bus != 0) begin
            if (finished) m_bus = 0;
        end else if (!was_empty) begin
            m_bus = 1;
        end else if (lsu_req_i && !lsu_we_i) begin
            m_bus = 2;
        end
    endtask

    task automatic compare_outputs();
        checkOutput("bus_req_o", 32'(bus_req_o), 32'(m_bus != 0));
        checkOutput("bus_we_o", 32'(bus_we_o), 32'(m_bus == 1));
        checkOutput("lsu_ack_o", 32'(lsu_ack_o), 32'(m_ack_pend || (m_bus == 2 && bus_ack_i)));
        checkOutput("lsu_err_o", 32'(lsu_err_o), 32'(m_bus == 2 && bus_err_i));
        checkOutput("sb_empty_o", 32'(sb_empty_o), 32'(sb_q.size() == 0));
        checkOutput("sb_full_o", 32'(sb_full_o), 32'(sb_q.size() == DEPTH));
        checkOutput("store_err_o", 32'(store_err_o), 32'(m_err_pulse));
        checkOutput("store_err_adr_o", store_err_adr_o, m_err_adr);
        if (m_bus == 2) begin
            checkOutput("bus_adr_o(load)", bus_adr_o, lsu_adr_i);
            checkOutput("bus_bsel_o(load)", 32'(bus_bsel_o), 32'(lsu_bsel_i));
            if (bus_ack_i) checkOutput("lsu_dat_o", lsu_dat_o, bus_dat_i);
        end else if (sb_q.size() > 0) begin
            checkOutput("bus_adr_o(head)", bus_adr_o, sb_q[0].adr);
            checkOutput("bus_dat_o(head)", bus_dat_o, sb_q[0].dat);
            checkOutput("bus_bsel_o(head)", 32'(bus_bsel_o), 32'(sb_q[0].bsel));
        end
    endtask

    task automatic drive_lsu();
        if (lsu_active && lsu_done) lsu_active = 1'b0;
        lsu_done = 1'b0;
        if (!lsu_active && op_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            cur_op = op_q.pop_front();
            lsu_active = 1'b1;
        end
        lsu_req_i = lsu_active;
        if (lsu_active) begin
            lsu_we_i = cur_op.we;
            lsu_adr_i = cur_op.adr;
            lsu_dat_i = cur_op.dat;
            lsu_bsel_i = cur_op.bsel;
        end else begin
            lsu_we_i = 1'($urandom_range(1));
            lsu_adr_i = $urandom;
            lsu_dat_i = $urandom;
            lsu_bsel_i = 4'($urandom_range(15));
        end
    endtask

    task automatic drive_bus();
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        bus_dat_i = fixed_rd_en ? fixed_rd : $urandom;
        if (!bus_req_o) begin
            wait_cnt = 0;
        end else if (!bus_hold) begin
            if (wait_cnt >= bus_delay) begin
                if ((err_arm && bus_adr_o == err_adr) || $urandom_range(99) < err_pct)
                    bus_err_i = 1'b1;
                else
                    bus_ack_i = 1'b1;
                wait_cnt = 0;
                bus_delay = $urandom_range(3);
            end else begin
                wait_cnt++;
            end
        end
    endtask

    // Model advances on the same edge as the DUT; inputs change 1 ns later and outputs are compared just before the next edge
    initial begin
        forever begin
            @(posedge clk);
            if (rst) model_step();
            else model_reset();
            #1;
            drive_lsu();
            drive_bus();
            #3;
            if (rst) compare_outputs();
            lsu_done = lsu_active && (lsu_ack_o || lsu_err_o);
        end
    end

    task automatic waitIdle(input string name);
        for (int i = 0; i < 8000; i++) begin
            if (op_q.size() == 0 && !lsu_active && sb_empty_o && !bus_req_o) return;
            @(negedge clk);
        end
        checkOutput(name, 32'd0, 32'd1);
    endtask

    initial begin
        bit          found;
        bit          seen;
        int          ack_cnt;
        int          req_cnt;
        logic [32:0] log_q[$];

        t3_adr = '{32'h10, 32'h14, 32'h18, 32'h40};
        t3_we  = '{1'b1, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        checkOutput("rst_bus_req", 32'(bus_req_o), 32'd0);
        checkOutput("rst_empty", 32'(sb_empty_o), 32'd1);
        checkOutput("rst_full", 32'(sb_full_o), 32'd0);
        checkOutput("rst_lsu_ack", 32'(lsu_ack_o), 32'd0);
        checkOutput("rst_store_err", 32'(store_err_o), 32'd0);
        checkOutput("rst_store_err_adr", store_err_adr_o, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single store into the empty buffer
        applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lsu_req_i) begin found = 1'b1; break; end
        end
        checkOutput("t1_req_seen", 32'(found), 32'd1);
        @(negedge clk);
        checkOutput("t1_ack_n1", 32'(lsu_ack_o), 32'd1);
        checkOutput("t1_bus_req_n1", 32'(bus_req_o), 32'd0);
        checkOutput("t1_empty_n1", 32'(sb_empty_o), 32'd0);
        @(negedge clk);
        checkOutput("t1_bus_req_n2", 32'(bus_req_o), 32'd1);
        checkOutput("t1_bus_we_n2", 32'(bus_we_o), 32'd1);
        checkOutput("t1_bus_adr_n2", bus_adr_o, 32'h100);
        checkOutput("t1_bus_dat_n2", bus_dat_o, 32'hDEADBEEF);
        checkOutput("t1_bus_bsel_n2", 32'(bus_bsel_o), 32'hF);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_ack_i) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checkOutput("t1_bus_ack_seen", 32'(found), 32'd1);
        @(negedge clk);
        checkOutput("t1_empty_after", 32'(sb_empty_o), 32'd1);
        checkOutput("t1_bus_req_gap", 32'(bus_req_o), 32'd0);
        waitIdle("t1_idle_timeout");

        // Nine stores against a stalled bus: eight fit, the ninth waits for a pop
        bus_hold = 1'b1;
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 32'h1000 + 32'(4 * i), $urandom, 4'hF);
        ack_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (lsu_ack_o) ack_cnt++;
        end
        checkOutput("t2_acks_while_full", 32'(ack_cnt), 32'd8);
        checkOutput("t2_full", 32'(sb_full_o), 32'd1);
        checkOutput("t2_ninth_pending", 32'(lsu_req_i && lsu_we_i), 32'd1);
        bus_hold = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_ack_i) seen = 1'b1;
            if (lsu_ack_o) begin
                ack_cnt++;
                checkOutput("t2_ninth_after_bus_ack", 32'(seen), 32'd1);
                break;
            end
        end
        checkOutput("t2_total_acks", 32'(ack_cnt), 32'd9);
        waitIdle("t2_idle_timeout");

        // A load queued behind three stores must wait until they have drained
        bus_hold = 1'b1;
        fixed_rd_en = 1'b1;
        fixed_rd = 32'h12345678;
        applyStimulus(1'b1, 32'h10, 32'hA0A0A0A0, 4'hF);
        applyStimulus(1'b1, 32'h14, 32'hB1B1B1B1, 4'h3);
        applyStimulus(1'b1, 32'h18, 32'hC2C2C2C2, 4'hC);
        applyStimulus(1'b0, 32'h40, 32'h0, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lsu_req_i && !lsu_we_i) begin found = 1'b1; break; end
        end
        checkOutput("t3_load_presented", 32'(found), 32'd1);
        checkOutput("t3_store_in_flight", 32'(bus_we_o), 32'd1);
        bus_hold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_req_o && (bus_ack_i || bus_err_i)) log_q.push_back({bus_we_o, bus_adr_o});
            if (lsu_ack_o && lsu_req_i && !lsu_we_i) begin
                checkOutput("t3_load_data", lsu_dat_o, 32'h12345678);
                found = 1'b1;
                break;
            end
        end
        checkOutput("t3_load_acked", 32'(found), 32'd1);
        checkOutput("t3_access_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                checkOutput($sformatf("t3_order_adr%0d", i), log_q[i][31:0], t3_adr[i]);
                checkOutput($sformatf("t3_order_we%0d", i), 32'(log_q[i][32]), 32'(t3_we[i]));
            end
        end
        fixed_rd_en = 1'b0;
        waitIdle("t3_idle_timeout");

        // Drained store that errors is reported on the side channel only
        err_arm = 1'b1;
        err_adr = 32'h200;
        applyStimulus(1'b1, 32'h200, 32'h55AA55AA, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_err_i) begin found = 1'b1; break; end
        end
        checkOutput("t4_bus_err_seen", 32'(found), 32'd1);
        checkOutput("t4_no_lsu_err", 32'(lsu_err_o), 32'd0);
        checkOutput("t4_err_adr_on_bus", bus_adr_o, 32'h200);
        @(negedge clk);
        checkOutput("t4_store_err_pulse", 32'(store_err_o), 32'd1);
        checkOutput("t4_store_err_adr", store_err_adr_o, 32'h200);
        checkOutput("t4_popped", 32'(sb_empty_o), 32'd1);
        @(negedge clk);
        checkOutput("t4_store_err_one_cycle", 32'(store_err_o), 32'd0);
        checkOutput("t4_store_err_adr_held", store_err_adr_o, 32'h200);
        waitIdle("t4_idle_timeout");

        // Load that errors is reported to the LSU in the same cycle
        err_adr = 32'h300;
        applyStimulus(1'b0, 32'h300, 32'h0, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_err_i) begin found = 1'b1; break; end
        end
        checkOutput("t5_bus_err_seen", 32'(found), 32'd1);
        checkOutput("t5_lsu_err", 32'(lsu_err_o), 32'd1);
        checkOutput("t5_no_lsu_ack", 32'(lsu_ack_o), 32'd0);
        @(negedge clk);
        checkOutput("t5_idle_next", 32'(bus_req_o), 32'd0);
        checkOutput("t5_no_store_err", 32'(store_err_o), 32'd0);
        err_arm = 1'b0;
        waitIdle("t5_idle_timeout");

        // Asynchronous reset with four stores queued and one on the bus
        bus_hold = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h500 + 32'(4 * i), $urandom, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (op_q.size() == 0 && !lsu_active) begin found = 1'b1; break; end
        end
        checkOutput("t6_stores_queued", 32'(found), 32'd1);
        checkOutput("t6_write_active", 32'(bus_req_o && bus_we_o), 32'd1);
        checkOutput("t6_not_empty", 32'(sb_empty_o), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("t6_req_drop", 32'(bus_req_o), 32'd0);
        checkOutput("t6_empty_now", 32'(sb_empty_o), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus_hold = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_req_o) req_cnt++;
        end
        checkOutput("t6_nothing_drains", 32'(req_cnt), 32'd0);
        checkOutput("t6_still_empty", 32'(sb_empty_o), 32'd1);

        // Random mix of loads and stores with random bus latency and errors
        gap_pct = 30;
        err_pct = 10;
        for (int i = 0; i < 300; i++)
            applyStimulus($urandom_range(99) < 65, $urandom & 32'hFFFF_FFFC, $urandom,
                          4'($urandom_range(1, 15)));
        waitIdle("rand_idle_timeout");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mor1kx_store_buffer_wb32.md
# mor1kx_store_buffer_wb32

Posted-write store buffer between the load/store unit (LSU) and the 32-bit Wishbone bus bridge. Stores are acknowledged to the LSU as soon as they are queued in a FIFO, then drained to the bridge one access at a time. Loads wait until the FIFO is empty and then pass straight through to the bridge, which keeps memory ordering strict. The downstream port uses the bridge's cpu_* request/ack convention: request is held until ack or err.

## Interface
- DEPTH_WIDTH, 3: log2 of FIFO entries (default 8 entries; legal 1..5).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- lsu_req_i  in  1  LSU access request; held until lsu_ack_o/lsu_err_o.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_adr_i  in  32  byte address.
- lsu_dat_i  in  32  store data.
- lsu_bsel_i  in  4  byte lane select.
- lsu_ack_o  out  1  access complete (store queued / load data valid).
- lsu_err_o  out  1  load bus error.
- lsu_dat_o  out  32  load data.
- bus_req_o  out  1  request to bridge.
- bus_we_o  out  1  write enable to bridge.
- bus_adr_o  out  32  address to bridge.
- bus_dat_o  out  32  write data to bridge.
- bus_bsel_o  out  4  byte select to bridge.
- bus_ack_i  in  1  bridge ack.
- bus_err_i  in  1  bridge error.
- bus_dat_i  in  32  bridge read data.
- sb_empty_o  out  1  FIFO holds no entries.
- sb_full_o  out  1  FIFO holds 2^DEPTH_WIDTH entries.
- store_err_o  out  1  one-cycle pulse: a drained store got bus_err_i.
- store_err_adr_o  out  32  address of the last errored store.

## Operation
- FIFO entry: {adr[31:0], dat[31:0], bsel[3:0]}. Write/read pointers are DEPTH_WIDTH bits and wrap modulo depth. count is DEPTH_WIDTH+1 bits.
- Push: lsu_req_i & lsu_we_i & !sb_full_o & !ack_r. Registered ack_r is set on a push and cleared otherwise, so each push gives exactly one lsu_ack_o cycle.
- lsu_ack_o = ack_r | (state==READ & bus_ack_i). lsu_err_o = state==READ & bus_err_i. lsu_dat_o = bus_dat_i.
- Pop: state==WRITE & (bus_ack_i | bus_err_i).
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- Full: a store is held off, with no ack, until a pop frees an entry.
- FSM states: IDLE, WRITE, READ.
  - IDLE -> WRITE if !sb_empty_o.
  - Else IDLE -> READ if lsu_req_i & !lsu_we_i.
  - WRITE -> IDLE on bus_ack_i | bus_err_i.
  - READ -> IDLE on bus_ack_i | bus_err_i.
- bus_req_o = state!=IDLE.
- bus_we_o = state==WRITE.
- In READ, bus_adr_o/bus_bsel_o = lsu_adr_i/lsu_bsel_i. Otherwise they carry the head entry. bus_dat_o always carries head data.
- Drained stores are never visible to the LSU as errors. On bus_err_i in WRITE:
  - the entry is still popped;
  - store_err_o pulses the next cycle;
  - store_err_adr_o loads the head address.
- A pending load is never issued while the FIFO is non-empty. Stores pushed while a load waits drain first.

## Timing
- Reset values:
  - state IDLE; pointers, count, ack_r and store_err_o 0; store_err_adr_o 0.
  - hence bus_req_o 0, lsu_ack_o 0, lsu_err_o 0, sb_empty_o 1, sb_full_o 0.
- Reset asserted mid-operation: all entries are discarded and bus_req_o drops immediately (asynchronous).
- Store into an idle, empty buffer, pushed in cycle N:
  - lsu_ack_o in N+1;
  - count=1 in N+1;
  - WRITE/bus_req_o from N+2.
- Bus ack in cycle M:
  - pop in M;
  - IDLE in M+1 with bus_req_o low for at least that cycle, so every bridge access is a separate request;
  - next WRITE in M+2.
- Load with an empty buffer, lsu_req_i in N:
  - READ in N+1;
  - lsu_ack_o and lsu_dat_o combinational with bus_ack_i.
- After ack the LSU may present a new request in the following cycle.
- Max store acceptance rate is one per 2 cycles. Max drain rate is one per 2 cycles plus bus latency.

## Test plan
- Store A=0x100, D=0xDEADBEEF, bsel=0xF into the empty buffer:
  - lsu_ack_o one cycle later;
  - bus_req_o/bus_we_o with A/D two cycles after push;
  - sb_empty_o=1 after bus ack.
- Nine back-to-back stores with the bus ack held off:
  - eight acks;
  - sb_full_o=1;
  - ninth store unacked until the first bus ack, then acked.
- Load issued with three stores queued:
  - the three stores drain in order 0x10, 0x14, 0x18;
  - only then READ with the load address;
  - lsu_dat_o=bus_dat_i=0x12345678 with lsu_ack_o.
- Drained store at 0x200 receives bus_err_i:
  - entry popped;
  - store_err_o pulses one cycle;
  - store_err_adr_o=0x200;
  - no lsu_err_o.
- Load receives bus_err_i: lsu_err_o=1 in the same cycle; FSM back in IDLE the next cycle.
- Reset with 4 entries queued and WRITE active: bus_req_o=0 and sb_empty_o=1 immediately; nothing drains after release.
